// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle unsigned multiply/divide unit owning HI/LO.
// A single 2*WIDTH-bit accumulator is sequenced as a shift-add multiplier
// (MULTU) or a restoring divider (DIVU), one step per cycle, WIDTH steps.
//
// Handshake: start is a one-cycle request, accepted only when busy=0
// (IDLE or DONE); while busy=1 start is ignored. done pulses for exactly
// one cycle when HI/LO hold the new result; busy and done are never both 1.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               op_q, op_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // Datapath step results for both operations
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_top;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_res;

   // One multiply or divide iteration computed from the current accumulator
   always_comb begin
      // Multiply: conditional add into the upper half, the carry shifts in at the top
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      // Divide: the partial remainder after the left shift is WIDTH+1 bits wide;
      // keeping the bit shifted out of the top makes large divisors compare correctly
      div_top  = acc_q[2*WIDTH-1:WIDTH-1];
      div_ge   = (div_top >= {1'b0, opnd_q});
      div_rem  = div_top[WIDTH-1:0] - opnd_q;
      div_next = {(div_ge ? div_rem : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
      step_res = op_q ? div_next : mul_next;
   end

   // Next-state, counter, accumulator and HI/LO update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            // MT* writes land on this edge; an accepted op overwrites them later
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
            if (start) begin
               state_d = S_RUN;
               op_d    = op;
               cnt_d   = CW'(WIDTH - 1);
               opnd_d  = op ? SrcB : SrcA;
               acc_d   = {{WIDTH{1'b0}}, (op ? SrcA : SrcB)};
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            acc_d = step_res;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_DONE;
               hi_d    = step_res[2*WIDTH-1:WIDTH];
               lo_d    = step_res[WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         op_q    <= 1'b0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, corner sequences and random ops against
// a plain-arithmetic model of MULTU/DIVU.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic         o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    string        name;
  } vec_t;

  vec_t tbl [8];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .SrcA  (src_a),
    .SrcB  (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .HI    (hi),
    .LO    (lo)
  );

  // reference model: {HI, LO} from plain arithmetic
  function automatic logic [2*W-1:0] ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    if (!o) return wa * wb;
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: issue one op, check the busy window, done pulse and result.
  // inj>0 drives an illegal start plus MT* writes in that RUN cycle.
  // chain=1 issues start in the current (DONE) cycle without advancing first.
  task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp, input int inj, input bit chain, input string name);
    logic [W-1:0] h0, l0;
    logic         win_ok;
    if (!chain) @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    h0 = hi; l0 = lo; win_ok = 1'b1;
    for (int c = 1; c <= W; c++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== h0 || lo !== l0) win_ok = 1'b0;
      if (c == inj) begin
        start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd2;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
      end
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    end
    check({name, " busy_window"}, {{(2*W-1){1'b0}}, win_ok}, {{(2*W-1){1'b0}}, 1'b1});
    check({name, " done_pulse"}, {{(2*W-2){1'b0}}, busy, done}, 64'b01);
    check({name, " hi_lo"}, {hi, lo}, exp_q.pop_front());
  endtask

  initial begin
    logic         ro;
    logic [W-1:0] ra, rb;

    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "mul_max"};
    tbl[1] = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       "div_100_7"};
    tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "div_max_1"};
    tbl[3] = '{1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "div_by_zero"};
    tbl[4] = '{1'b0, 32'h80000000, 32'd2,        32'd1,        32'd0,        "mul_carry"};
    tbl[5] = '{1'b1, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'd1,        "div_big_divisor"};
    tbl[6] = '{1'b1, 32'd7,        32'd100,      32'd7,        32'd0,        "div_small"};
    tbl[7] = '{1'b0, 32'd0,        32'h12345,    32'd0,        32'd0,        "mul_zero"};

    // reset state
    #3;
    check("reset_flags", {{(2*W-2){1'b0}}, busy, done}, '0);
    check("reset_hi_lo", {hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;

    // table vectors; odd entries start in the DONE cycle of the previous op
    for (int i = 0; i < 8; i++)
      do_op(tbl[i].o, tbl[i].a, tbl[i].b, {tbl[i].exp_hi, tbl[i].exp_lo}, 0, (i % 2) == 1, tbl[i].name);

    // start/hi_we/lo_we during RUN are ignored
    do_op(1'b0, 32'd3, 32'd4, {32'd0, 32'd12}, 5, 1'b0, "ignore_in_run");
    @(negedge clk);
    check("idle_after_done", {{(2*W-2){1'b0}}, busy, done}, '0);

    // asynchronous reset in cycle 10 of a MULTU
    start = 1'b1; op = 1'b0; src_a = 32'hFFFF; src_b = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_flags", {{(2*W-2){1'b0}}, busy, done}, '0);
    check("async_rst_hi_lo", {hi, lo}, '0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 32'd6, 32'd7, {32'd0, 32'd42}, 0, 1'b0, "mul_after_rst");

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'hCAFE, 32'd42});
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'hCAFE, 32'h1234});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h5A5A, 32'h5A5A});

    // start together with MTHI: write lands on accept, result overwrites later
    start = 1'b1; op = 1'b0; src_a = 32'd2; src_b = 32'd3;
    hi_we = 1'b1; wdata = 32'hBEEF;
    exp_q.push_back(ref_model(1'b0, 32'd2, 32'd3));
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("write_on_accept", {hi, lo}, {32'hBEEF, 32'h5A5A});
    repeat (W) @(negedge clk);
    check("write_then_result", {hi, lo}, exp_q.pop_front());

    // random ops against the model
    for (int i = 0; i < 24; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 255));
        2: rb = '0;
        default: rb = $urandom | 32'h80000000;
      endcase
      do_op(ro, ra, rb, ref_model(ro, ra, rb), 0, 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
